// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding and
// the default bit period.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last and
// second-to-last cycle of each serial bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_bit_end,
  output logic o_pre_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));
  // One cycle early, so registered outputs can line up with the bit end.
  assign o_pre_end = (r_cnt == CW'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and serializes each word as a UART frame:
// start, data LSB first, optional even parity, one or two stop bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            dbg_state
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t           r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic [BW-1:0]         r_bit, w_bit;
  logic                  r_stop, w_stop;
  logic                  r_par, w_par;
  logic                  r_tx, w_tx;
  logic                  r_busy;
  logic                  r_done, w_done;
  logic                  w_bit_end, w_pre_end, w_last_stop;
  logic                  w_can_pop, w_pop, w_baud_clr;

  // Reset gates the pop so a held reset never drains the FIFO.
  assign w_can_pop   = tx_en && !fifo_empty && !reset;
  assign w_last_stop = (STOP_BITS == 2) ? r_stop : 1'b1;
  assign w_pop       = w_can_pop && ((r_state == ST_IDLE) ||
                       (r_state == ST_STOP && w_bit_end && w_last_stop));
  assign w_baud_clr  = (r_state == ST_IDLE) || w_pop;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .rst       (reset),
    .i_clr     (w_baud_clr),
    .o_bit_end (w_bit_end),
    .o_pre_end (w_pre_end)
  );

  always_comb begin
    w_next  = r_state;
    w_tx    = r_tx;
    w_shift = r_shift;
    w_bit   = r_bit;
    w_stop  = r_stop;
    w_par   = r_par;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: w_tx = 1'b1;
      ST_START: begin
        if (w_bit_end) begin
          w_next  = ST_DATA;
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit == BW'(DATA_WIDTH - 1)) begin
            w_bit = '0;
            if (PARITY_EN != 0) begin
              w_next = ST_PARITY;
              w_tx   = r_par;
            end else begin
              w_next = ST_STOP;
              w_tx   = 1'b1;
            end
          end else begin
            w_bit   = r_bit + 1'b1;
            w_tx    = r_shift[0];
            w_shift = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_next = ST_STOP;
          w_tx   = 1'b1;
        end
      end
      ST_STOP: begin
        w_done = w_pre_end && w_last_stop;
        if (w_bit_end) begin
          if (!w_last_stop) begin
            w_stop = 1'b1;
          end else begin
            w_stop = 1'b0;
            w_next = ST_IDLE;
            w_tx   = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // A pop from IDLE or the final stop cycle starts the next frame directly.
    if (w_pop) begin
      w_shift = fifo_rd_data;
      w_par   = ^fifo_rd_data;
      w_bit   = '0;
      w_stop  = 1'b0;
      w_next  = ST_START;
      w_tx    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_shift <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= w_done;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_stop  <= w_stop;
      r_par   <= w_par;
    end
  end

  assign fifo_rd    = w_pop;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign dbg_state  = r_state;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that sits directly downstream of the byte FIFO. It drains words from the FIFO read port and serializes each one as an asynchronous UART frame: start bit, data LSB first, optional even parity, then stop bit(s). Each word is popped exactly once and never lost or duplicated, except when reset is asserted mid-frame.

## Interface
- DATA_WIDTH, 8, data bits per frame; matches the FIFO DATA_WIDTH
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be ≥ 2
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits
- STOP_BITS, 1, number of stop bits; 1 or 2
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- tx_en  input  1  permits starting new frames; a frame in flight always completes
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_data  input  DATA_WIDTH  FIFO head word, valid combinationally while fifo_empty=0
- fifo_rd  output  1  one-cycle pop strobe to the FIFO
- tx  output  1  serial line, registered, idles high
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse when a frame finishes

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If tx_en=1 and fifo_empty=0: assert fifo_rd for this cycle, capture fifo_rd_data into the shift register, and go to START.
  - Otherwise hold, with tx=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Shift out DATA_WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Then go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx = XOR of the captured word, for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
- Last cycle of STOP:
  - frame_done=1.
  - If tx_en=1 and fifo_empty=0: assert fifo_rd, capture the next word, and go directly to START, so frames run back to back with no idle gap.
  - Otherwise go to IDLE.
- fifo_rd is only ever asserted when fifo_empty=0 in the same cycle; no pop is issued speculatively.
- busy=1 in every state except IDLE.
- tx_en deasserted mid-frame: the current frame completes normally and no further pop is issued.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits; counts 0 to CLKS_PER_BIT-1, then wraps.
  - Bit counter: $clog2(DATA_WIDTH+1) bits.
  - Stop counter: 1 bit.
- Reset values, applied asynchronously: state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, all counters 0.
- Reset mid-frame: tx returns high immediately and the word in flight is discarded. After reset releases, the next pop fetches the next FIFO word.

## Timing
- Pop-to-line latency: tx falls on the first edge after the pop cycle.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, measured from the tx falling edge.
- frame_done coincides with the final stop-bit cycle.
- When back to back, the next pop occurs in the same cycle as frame_done.
- fifo_rd is combinational from the state, fifo_empty, tx_en and the counters. tx, busy and frame_done are registered.
- Throughput: at most one pop per frame.

## Structure
- Package uart_pkg holds:
  - the state encoding localparams for IDLE, START, DATA, PARITY and STOP;
  - the default bit-period constant.
- Sub-module uart_baud_cnt: a parameterized CLKS_PER_BIT divider with a clear input and a bit_end pulse output. The FSM clears it on each frame start.
- Parameter checks at elaboration: CLKS_PER_BIT ≥ 2; STOP_BITS ∈ {1, 2}.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=8.
- Reset: hold fifo_empty=1 for 20 cycles after reset -> tx=1, busy=0, fifo_rd never asserted.
- Single word 0xA5:
  - One fifo_rd pulse.
  - tx holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
  - frame_done pulses 40 cycles after tx falls; busy then drops.
- Back to back 0x00 then 0xFF:
  - The second fifo_rd coincides with the first frame_done.
  - tx stays low 36 cycles, then high 4 cycles, low 4 cycles, then high 36 cycles.
  - Exactly 2 pops and 80 busy cycles.
- PARITY_EN=1, word 0x07: parity bit is 1; frame is 44 cycles.
- With STOP_BITS=2, the stop period is 8 cycles.
- Reset mid-frame:
  - Assert reset during data bit 3 -> tx=1 within the same cycle.
  - After release with the FIFO still non-empty, a fresh pop occurs; the discarded word is not retransmitted.
- tx_en:
  - tx_en=0 with fifo_empty=0 -> no pop for 50 cycles.
  - Dropping tx_en mid-frame -> the frame completes and there is no next pop.
